// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared defaults, channel state type and helpers for
// the programmable clock divider (clock_div_prog / clock_div_ch).
package clock_div_pkg;

    // Default divide-ratio/counter width and reset ratio.
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_DIV_RATIO = 8;

    // Per-channel run state.
    // CH_IDLE: not enabled, phase counter parked at 0.
    // CH_RUN : enabled and counting phases.
    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    // Length of the low phase for ratio n: ceil(n/2).
    function automatic logic [31:0] half_up(input logic [31:0] n);
        return (n >> 1) + {31'd0, n[0]};
    endfunction

endpackage

// File: rtl/clock_div_ch.sv
// clock_div_ch: one programmable divider channel.
// Ports: clk, rst (sync, active-high), en, load, sync, div[CNT_W];
//        div_clk (registered divided clock), tick (rise pulse),
//        pend (ratio waiting for the period boundary).
module clock_div_ch
    import clock_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             sync,
    input  logic [CNT_W-1:0] div,
    output logic             div_clk,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_R = CNT_W'(DEF_DIV);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ratio_q, ratio_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic [CNT_W-1:0] ratio_nx;
    logic [CNT_W-1:0] low_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CH_IDLE;
            cnt_q    <= '0;
            ratio_q  <= RST_R;
            shadow_q <= RST_R;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ratio_q  <= ratio_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ratio_d  = ratio_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        wrap     = 1'b0;
        ratio_nx = ratio_q;

        if (!en) begin
            // Stopped: no boundary will come, so apply ratios now.
            state_d = CH_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
            if (load) begin
                ratio_d  = div;
                shadow_d = div;
            end else if (pend_q) begin
                ratio_d = shadow_q;
            end
        end else begin
            state_d = CH_RUN;
            // Starting from idle, a sync restart and a stopped (N=0)
            // channel all behave as a period boundary.
            wrap = (state_q == CH_IDLE) || sync ||
                   (ratio_q == '0) || (cnt_q == ratio_q - ONE);
            if (wrap) begin
                if (load) begin
                    ratio_nx = div;
                    shadow_d = div;
                end else if (pend_q) begin
                    ratio_nx = shadow_q;
                end
                ratio_d = ratio_nx;
                pend_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ONE;
                if (load) begin
                    shadow_d = div;
                    pend_d   = 1'b1;
                end
            end
        end

        low_nx = CNT_W'(half_up(32'(ratio_nx)));

        // Outputs are registered from the phase entered at this edge.
        if (en) begin
            if (ratio_nx == ONE) begin
                tick_d = 1'b1;
            end else if (ratio_nx != '0) begin
                clk_d  = (cnt_d >= low_nx);
                tick_d = (cnt_d == low_nx);
            end
        end
    end

    assign div_clk = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/clock_div_prog.sv
// clock_div_prog: NUM_CH independent programmable clock dividers.
// Ports: i_clk, i_rst (sync, active-high), i_en/i_load[NUM_CH],
//        i_div[NUM_CH*CNT_W], o_clk/o_tick/o_pend[NUM_CH];
//        i_sync only when CLK_DIV_SYNC_EN is defined.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_RATIO
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH-1:0]       i_en,
    input  logic [NUM_CH*CNT_W-1:0] i_div,
    input  logic [NUM_CH-1:0]       i_load,
`ifdef CLK_DIV_SYNC_EN
    input  logic                    i_sync,
`endif
    output logic [NUM_CH-1:0]       o_clk,
    output logic [NUM_CH-1:0]       o_tick,
    output logic [NUM_CH-1:0]       o_pend
);

    logic sync;

`ifdef CLK_DIV_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clock_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (i_clk),
            .rst     (i_rst),
            .en      (i_en[k]),
            .load    (i_load[k]),
            .sync    (sync),
            .div     (i_div[k*CNT_W +: CNT_W]),
            .div_clk (o_clk[k]),
            .tick    (o_tick[k]),
            .pend    (o_pend[k])
        );
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// tb_clock_div_prog: scoreboard bench for clock_div_prog.
// Expected per-cycle {clk,tick,pend} are queued when stimulus is driven.
module tb_clock_div_prog;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic c;
        logic t;
        logic p;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*CNT_W-1:0] div;
    logic                    sync;
    logic [NUM_CH-1:0]       oc;
    logic [NUM_CH-1:0]       ot;
    logic [NUM_CH-1:0]       op;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    clock_div_prog #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (8)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_div  (div),
        .i_load (load),
`ifdef CLK_DIV_SYNC_EN
        .i_sync (sync),
`endif
        .o_clk  (oc),
        .o_tick (ot),
        .o_pend (op)
    );

    // One clock; outputs sampled 1 time unit after the edge.
    // Load and sync are single-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        load = '0;
        sync = 1'b0;
    endtask

    task automatic set_div(input int ch, input int v);
        div[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Expected waveform of ratio n starting at phase ph0.
    task automatic push_seg(input int ch, input int n, input int ph0,
                            input int len, input logic p);
        for (int i = 0; i < len; i++) begin
            int   ph;
            int   h;
            exp_t e;
            ph  = (n == 0) ? 0 : (ph0 + i) % n;
            h   = (n + 1) / 2;
            e.c = (n >= 2) && (ph >= h);
            e.t = (n == 1) || ((n >= 2) && (ph == h));
            e.p = p;
            if (ch == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (oc !== 2'b00) begin
            errors++;
            $display("FAIL reset_clk got %b required 00", oc);
        end
        checks++;
        if (ot !== 2'b00) begin
            errors++;
            $display("FAIL reset_tick got %b required 00", ot);
        end
        checks++;
        if (op !== 2'b00) begin
            errors++;
            $display("FAIL reset_pend got %b required 00", op);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_div8();
        en = 2'b01;
        push_seg(0, 8, 0, 24, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL div8 got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
            checks++;
            if ({oc[1], ot[1], op[1]} !== 3'b000) begin
                errors++;
                $display("FAIL div8_ch1_idle got %b required 000",
                         {oc[1], ot[1], op[1]});
            end
        end
        en = 2'b00;
        step();
        checks++;
        if ({oc[0], ot[0]} !== 2'b00) begin
            errors++;
            $display("FAIL disable got %b required 00", {oc[0], ot[0]});
        end
    endtask

    task automatic test_small(input int n, input int len);
        set_div(0, n);
        load[0] = 1'b1;
        step();
        checks++;
        if (op[0] !== 1'b0) begin
            errors++;
            $display("FAIL load_idle_pend n=%0d got %b required 0",
                     n, op[0]);
        end
        en[0] = 1'b1;
        push_seg(0, n, 0, len, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL div%0d got %b required %b",
                         n, {oc[0], ot[0], op[0]}, e);
            end
        end
        en[0] = 1'b0;
        step();
    endtask

    task automatic test_reload();
        set_div(0, 8);
        load[0] = 1'b1;
        step();
        en[0] = 1'b1;
        push_seg(0, 8, 0, 3, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL reload_pre got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        set_div(0, 4);
        load[0] = 1'b1;
        push_seg(0, 8, 3, 5, 1'b1);
        push_seg(0, 4, 0, 12, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL reload_4 got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        en[0] = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        set_div(0, 8);
        load[0] = 1'b1;
        step();
        en[0] = 1'b1;
        push_seg(0, 8, 0, 2, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL b2b_pre got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        set_div(0, 6);
        load[0] = 1'b1;
        push_seg(0, 8, 2, 1, 1'b1);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL b2b_first got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        set_div(0, 10);
        load[0] = 1'b1;
        push_seg(0, 8, 3, 5, 1'b1);
        push_seg(0, 10, 0, 20, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL b2b_last_wins got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
    endtask

    task automatic test_boundary_load();
        set_div(0, 6);
        load[0] = 1'b1;
        push_seg(0, 6, 0, 12, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL boundary_load got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        push_seg(0, 6, 0, 2, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL rstmid_pre got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        set_div(0, 3);
        load[0] = 1'b1;
        push_seg(0, 6, 2, 1, 1'b1);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL rstmid_pend got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        rst = 1'b1;
        step();
        checks++;
        if ({oc, ot, op} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_zero got %b required 000000",
                     {oc, ot, op});
        end
        rst = 1'b0;
        push_seg(0, 8, 0, 16, 1'b0);
        while (q0.size() > 0) begin
            exp_t e;
            step();
            e = q0.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e) begin
                errors++;
                $display("FAIL rstmid_def8 got %b required %b",
                         {oc[0], ot[0], op[0]}, e);
            end
        end
        en = 2'b00;
        step();
    endtask

    task automatic test_two_ch();
        set_div(0, 3);
        set_div(1, 6);
        load = 2'b11;
        step();
        en = 2'b11;
        push_seg(0, 3, 0, 12, 1'b0);
        push_seg(1, 6, 0, 12, 1'b0);
        while (q0.size() > 0) begin
            exp_t e0;
            exp_t e1;
            step();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e0) begin
                errors++;
                $display("FAIL two_ch0 got %b required %b",
                         {oc[0], ot[0], op[0]}, e0);
            end
            checks++;
            if ({oc[1], ot[1], op[1]} !== e1) begin
                errors++;
                $display("FAIL two_ch1 got %b required %b",
                         {oc[1], ot[1], op[1]}, e1);
            end
        end
        en = 2'b00;
        step();
    endtask

`ifdef CLK_DIV_SYNC_EN
    task automatic test_sync();
        set_div(0, 4);
        set_div(1, 8);
        load = 2'b11;
        step();
        en = 2'b10;
        for (int i = 0; i < 3; i++) step();
        en = 2'b11;
        for (int i = 0; i < 2; i++) step();
        sync = 1'b1;
        push_seg(0, 4, 0, 8, 1'b0);
        push_seg(1, 8, 0, 8, 1'b0);
        while (q0.size() > 0) begin
            exp_t e0;
            exp_t e1;
            step();
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            checks++;
            if ({oc[0], ot[0], op[0]} !== e0) begin
                errors++;
                $display("FAIL sync_ch0 got %b required %b",
                         {oc[0], ot[0], op[0]}, e0);
            end
            checks++;
            if ({oc[1], ot[1], op[1]} !== e1) begin
                errors++;
                $display("FAIL sync_ch1 got %b required %b",
                         {oc[1], ot[1], op[1]}, e1);
            end
        end
        en = 2'b00;
        step();
    endtask
`endif

    initial begin
        rst  = 1'b1;
        en   = '0;
        load = '0;
        div  = '0;
        sync = 1'b0;
        test_reset();
        test_div8();
        test_small(5, 15);
        test_small(1, 6);
        test_small(0, 6);
        test_reload();
        test_back_to_back();
        test_boundary_load();
        test_reset_mid();
        test_two_ch();
`ifdef CLK_DIV_SYNC_EN
        test_sync();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
